arch_map_retire: RTL

- Retire-side return path for the physical register free list.
- Holds the architectural map table (AMT): the committed arch-reg to PR mapping.
- Each cycle, takes up to 3 retiring instructions from the ROB, resolves each destination's previous committed PR (Told), updates the AMT, and emits the Told set as registered free requests to the free list (RetireEN/RetireReg).
- Also supplies the full AMT snapshot used to rebuild the rename map on branch-mispredict recovery.

---
 rtl/arch_map_retire_pkg.sv | 24 ++
 rtl/arch_map_retire_told_chain.sv | 43 ++++
 rtl/arch_map_retire.sv | 105 ++++++++++
 3 files changed

// File: rtl/arch_map_retire_pkg.sv
// Shared types and sizes for the retire-side architectural map table.
// The physical register index width comes from the PR macro (defaults to 6).
`ifndef PR
`define PR 6
`endif

package arch_map_retire_pkg;

  localparam int WAYS   = 3;
  localparam int AR_NUM = 32;
  localparam int AR_W   = 5;
  localparam int PR_W   = `PR;
  localparam int WAY_W  = $clog2(WAYS);

  typedef logic [PR_W-1:0] pr_t;
  typedef logic [AR_W-1:0] ar_t;

  typedef struct packed {
    logic valid;
    ar_t  ar;
    pr_t  pr;
  } retire_pkt_t;

endpackage

// File: rtl/arch_map_retire_told_chain.sv
// amt_told_chain: combinational Told resolution across the retire group.
// Arch 0 never counts as a write; younger same-arch ways forward the PR of
// the older way instead of the stale AMT value.
module amt_told_chain
  import arch_map_retire_pkg::*;
(
  input  retire_pkt_t [WAYS-1:0]              pkt,
  input  logic        [AR_NUM-1:0][PR_W-1:0]  amt,
  output logic        [WAYS-1:0][PR_W-1:0]    told,
  output logic        [WAYS-1:0]              eff,
  output logic        [AR_NUM-1:0]            wr_en,
  output logic        [AR_NUM-1:0][WAY_W-1:0] wr_sel
);

  // Per-way effective flag and previous committed PR (oldest way first).
  always_comb begin
    eff  = '0;
    told = '0;
    for (int k = 0; k < WAYS; k++) begin
      eff[k]  = pkt[k].valid && (pkt[k].ar != '0);
      told[k] = amt[pkt[k].ar];
      for (int j = 0; j < WAYS; j++) begin
        if (j < k && eff[j] && pkt[j].ar == pkt[k].ar)
          told[k] = pkt[j].pr;
      end
    end
  end

  // Per-arch write enable; the youngest effective writer wins.
  always_comb begin
    wr_en  = '0;
    wr_sel = '0;
    for (int a = 0; a < AR_NUM; a++) begin
      for (int k = 0; k < WAYS; k++) begin
        if (eff[k] && pkt[k].ar == AR_W'(a)) begin
          wr_en[a]  = 1'b1;
          wr_sel[a] = WAY_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/arch_map_retire.sv
// arch_map_retire: committed arch->PR map plus registered free requests
// back to the free list. Optional macro ARCH_MAP_CHECK_EN adds a sticky
// amt_error flag and an amt_display copy of the map.
module arch_map_retire
  import arch_map_retire_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WAYS-1:0]                RetireEN,
  input  logic [WAYS-1:0][AR_W-1:0]      RetireArch,
  input  logic [WAYS-1:0][PR_W-1:0]      RetirePR,
  input  logic                           BPRecoverEN,
  output logic [WAYS-1:0]                FreeEN,
  output logic [WAYS-1:0][PR_W-1:0]      FreeReg,
`ifdef ARCH_MAP_CHECK_EN
  output logic                           amt_error,
  output logic [AR_NUM-1:0][PR_W-1:0]    amt_display,
`endif
  output logic [AR_NUM-1:0][PR_W-1:0]    AMTSnapshot
);

  retire_pkt_t [WAYS-1:0]              pkt;
  logic        [AR_NUM-1:0][PR_W-1:0]  amt_q;
  logic        [WAYS-1:0][PR_W-1:0]    told;
  logic        [WAYS-1:0]              eff;
  logic        [AR_NUM-1:0]            wr_en;
  logic        [AR_NUM-1:0][WAY_W-1:0] wr_sel;

  // Recovery does not stall retire; the snapshot is simply the current map.
  logic unused_recover;
  assign unused_recover = BPRecoverEN;

  // Pack the ROB retire ports into per-way packets.
  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      pkt[k].valid = RetireEN[k];
      pkt[k].ar    = RetireArch[k];
      pkt[k].pr    = RetirePR[k];
    end
  end

  amt_told_chain u_told_chain (
    .pkt    (pkt),
    .amt    (amt_q),
    .told   (told),
    .eff    (eff),
    .wr_en  (wr_en),
    .wr_sel (wr_sel)
  );

  // AMT update: identity at reset, youngest effective writer per entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < AR_NUM; a++)
        amt_q[a] <= PR_W'(a);
    end else begin
      for (int a = 0; a < AR_NUM; a++)
        if (wr_en[a])
          amt_q[a] <= RetirePR[wr_sel[a]];
    end
  end

  // Registered free requests, one cycle after retire; idle ways carry zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      FreeEN  <= '0;
      FreeReg <= '0;
    end else begin
      FreeEN <= eff;
      for (int k = 0; k < WAYS; k++)
        FreeReg[k] <= eff[k] ? told[k] : '0;
    end
  end

  assign AMTSnapshot = amt_q;

`ifdef ARCH_MAP_CHECK_EN
  logic err_now;

  // Flag a retiring PR that equals its Told or is still mapped elsewhere.
  always_comb begin
    err_now = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (eff[k]) begin
        if (RetirePR[k] == told[k])
          err_now = 1'b1;
        for (int a = 0; a < AR_NUM; a++)
          if (amt_q[a] == RetirePR[k] && !wr_en[a])
            err_now = 1'b1;
      end
    end
  end

  // Sticky error, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      amt_error <= 1'b0;
    else if (err_now)
      amt_error <= 1'b1;
  end

  assign amt_display = amt_q;
`endif

endmodule
